// File: rtl/fifo_s1_sf_pkg.sv
// Shared constants and pointer-wrap helper for the fifo_s1_sf FIFO.
package fifo_s1_sf_pkg;

    localparam int ERR_MODE_STICKY_DIAG = 0;
    localparam int ERR_MODE_STICKY      = 1;
    localparam int ERR_MODE_PULSE       = 2;

    localparam int RST_MODE_MEM = 0;
    localparam int RST_MODE_PTR = 1;

    // Advance a pointer, wrapping from depth-1 to 0 by explicit compare so
    // non-power-of-2 depths work. Pointers never exceed 8 bits (depth<=256).
    function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input int depth);
        if (int'(ptr) == depth - 1) return 8'd0;
        return ptr + 8'd1;
    endfunction

endpackage

// File: rtl/fifo_s1_sf_ctl.sv
// Pointer, occupancy count, registered status flags and error for fifo_s1_sf.
// Optional checks are compiled only with FIFO_S1_SF_ASSERT_EN defined.
module fifo_s1_sf_ctl
    import fifo_s1_sf_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int AE_LEVEL = 1,
    parameter int AF_LEVEL = 1,
    parameter int ERR_MODE = 0,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push_req_n,
    input  logic          i_pop_req_n,
    input  logic          i_diag_n,
    output logic          o_wr_en,
    output logic [PW-1:0] o_wr_ptr,
    output logic [PW-1:0] o_rd_ptr,
    output logic          o_empty,
    output logic          o_almost_empty,
    output logic          o_half_full,
    output logic          o_almost_full,
    output logic          o_full,
    output logic          o_error
);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] C_HF    = CW'((DEPTH + 1) / 2);
    localparam logic [CW-1:0] C_AF    = CW'(DEPTH - AF_LEVEL);

    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_empty, r_aempty, r_hf, r_af, r_full, r_err;

    logic          w_push, w_pop, w_is_full, w_is_empty;
    logic          w_wr_en, w_rd_en, w_ovf, w_unf, w_err_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;

    // Accept/reject decisions: a full FIFO drops pushes, an empty one ignores pops.
    always_comb begin
        w_push       = ~i_push_req_n;
        w_pop        = ~i_pop_req_n;
        w_is_full    = (r_count == C_DEPTH);
        w_is_empty   = (r_count == '0);
        w_wr_en      = w_push & ~w_is_full;
        w_rd_en      = w_pop & ~w_is_empty;
        w_ovf        = w_push & w_is_full;
        w_unf        = w_pop & w_is_empty;
        w_count_nxt  = r_count + CW'(w_wr_en) - CW'(w_rd_en);
        w_wr_ptr_nxt = PW'(ptr_inc(8'(r_wr_ptr), DEPTH));
        w_rd_ptr_nxt = PW'(ptr_inc(8'(r_rd_ptr), DEPTH));
    end

    // Error next-state: sticky (with or without diag) or a one-cycle pulse.
    always_comb begin
        w_err_nxt = w_ovf | w_unf;
        if (ERR_MODE == ERR_MODE_STICKY_DIAG)
            w_err_nxt = r_err | w_ovf | w_unf | ~i_diag_n;
        else if (ERR_MODE == ERR_MODE_STICKY)
            w_err_nxt = r_err | w_ovf | w_unf;
    end

    // State update; flags come from next-state count so they track the accepting edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_hf     <= 1'b0;
            r_af     <= 1'b0;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rd_en) r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_empty  <= (w_count_nxt == '0);
            r_aempty <= (w_count_nxt <= C_AE);
            r_hf     <= (w_count_nxt >= C_HF);
            r_af     <= (w_count_nxt >= C_AF);
            r_full   <= (w_count_nxt == C_DEPTH);
            r_err    <= w_err_nxt;
        end
    end

    assign o_wr_en        = w_wr_en;
    assign o_wr_ptr       = r_wr_ptr;
    assign o_rd_ptr       = r_rd_ptr;
    assign o_empty        = r_empty;
    assign o_almost_empty = r_aempty;
    assign o_half_full    = r_hf;
    assign o_almost_full  = r_af;
    assign o_full         = r_full;
    assign o_error        = r_err;

`ifdef FIFO_S1_SF_ASSERT_EN
    if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
        $error("fifo_s1_sf: depth out of range");
    end
    if (AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_s1_sf: ae_level out of range");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
        $error("fifo_s1_sf: af_level out of range");
    end
    if (ERR_MODE < 0 || ERR_MODE > 2) begin : g_bad_err
        $error("fifo_s1_sf: err_mode out of range");
    end

    a_count_le_depth: assert property (@(posedge i_clk) disable iff (i_rst) r_count <= C_DEPTH);
    a_not_full_empty: assert property (@(posedge i_clk) disable iff (i_rst) !(r_full && r_empty));

    // Report each rejected request.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_ovf) $error("fifo_s1_sf: overflow");
        if (!i_rst && w_unf) $error("fifo_s1_sf: underflow");
    end
`endif

endmodule

// File: rtl/fifo_s1_sf.sv
// Single-clock FWFT FIFO with registered status flags and overflow/underflow error.
// Define FIFO_S1_SF_ASSERT_EN to compile parameter and protocol checks.
module fifo_s1_sf
    import fifo_s1_sf_pkg::*;
#(
    parameter int width    = 8,
    parameter int depth    = 4,
    parameter int ae_level = 1,
    parameter int af_level = 1,
    parameter int err_mode = 0,
    parameter int rst_mode = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req_n,
    input  logic             pop_req_n,
    input  logic             diag_n,
    input  logic [width-1:0] data_in,
    output logic             empty,
    output logic             almost_empty,
    output logic             half_full,
    output logic             almost_full,
    output logic             full,
    output logic             error,
    output logic [width-1:0] data_out
);

    localparam int PW = $clog2(depth);

    logic [width-1:0] r_mem [depth];
    logic             w_wr_en;
    logic [PW-1:0]    w_wr_ptr, w_rd_ptr;

    fifo_s1_sf_ctl #(
        .DEPTH    (depth),
        .AE_LEVEL (ae_level),
        .AF_LEVEL (af_level),
        .ERR_MODE (err_mode)
    ) u_ctl (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_push_req_n   (push_req_n),
        .i_pop_req_n    (pop_req_n),
        .i_diag_n       (diag_n),
        .o_wr_en        (w_wr_en),
        .o_wr_ptr       (w_wr_ptr),
        .o_rd_ptr       (w_rd_ptr),
        .o_empty        (empty),
        .o_almost_empty (almost_empty),
        .o_half_full    (half_full),
        .o_almost_full  (almost_full),
        .o_full         (full),
        .o_error        (error)
    );

    // Storage write; reset blocks writes and optionally scrubs the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (rst_mode == RST_MODE_MEM)
                for (int i = 0; i < depth; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_wr_ptr] <= data_in;
        end
    end

    // Head word is read combinationally: the first word falls through.
    assign data_out = r_mem[w_rd_ptr];

`ifdef FIFO_S1_SF_ASSERT_EN
    if (width < 1 || width > 256) begin : g_bad_width
        $error("fifo_s1_sf: width out of range");
    end
    if (rst_mode < 0 || rst_mode > 1) begin : g_bad_rst
        $error("fifo_s1_sf: rst_mode out of range");
    end
`endif

endmodule

// File: tb/tb_fifo_s1_sf.sv
// Bench for fifo_s1_sf: directed scenarios plus randomized traffic against a queue model.
module tb_fifo_s1_sf;

    logic       clk = 1'b0;
    logic       rst = 1'b1, push_n = 1'b1, pop_n = 1'b1, diag_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic [3:0] emp, aemp, hf, af, ful, err;
    logic [7:0] dout [4];
    int         n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    // u0..u2: depth 2 in err_mode 0/1/2; u3: depth 5, pulse error, pointer-only reset
    fifo_s1_sf #(.width(8), .depth(2), .ae_level(1), .af_level(1), .err_mode(0), .rst_mode(0)) u0 (
        .clk(clk), .rst(rst), .push_req_n(push_n), .pop_req_n(pop_n), .diag_n(diag_n), .data_in(din),
        .empty(emp[0]), .almost_empty(aemp[0]), .half_full(hf[0]), .almost_full(af[0]), .full(ful[0]),
        .error(err[0]), .data_out(dout[0]));
    fifo_s1_sf #(.width(8), .depth(2), .ae_level(1), .af_level(1), .err_mode(1), .rst_mode(0)) u1 (
        .clk(clk), .rst(rst), .push_req_n(push_n), .pop_req_n(pop_n), .diag_n(diag_n), .data_in(din),
        .empty(emp[1]), .almost_empty(aemp[1]), .half_full(hf[1]), .almost_full(af[1]), .full(ful[1]),
        .error(err[1]), .data_out(dout[1]));
    fifo_s1_sf #(.width(8), .depth(2), .ae_level(1), .af_level(1), .err_mode(2), .rst_mode(0)) u2 (
        .clk(clk), .rst(rst), .push_req_n(push_n), .pop_req_n(pop_n), .diag_n(diag_n), .data_in(din),
        .empty(emp[2]), .almost_empty(aemp[2]), .half_full(hf[2]), .almost_full(af[2]), .full(ful[2]),
        .error(err[2]), .data_out(dout[2]));
    fifo_s1_sf #(.width(8), .depth(5), .ae_level(2), .af_level(1), .err_mode(2), .rst_mode(1)) u3 (
        .clk(clk), .rst(rst), .push_req_n(push_n), .pop_req_n(pop_n), .diag_n(diag_n), .data_in(din),
        .empty(emp[3]), .almost_empty(aemp[3]), .half_full(hf[3]), .almost_full(af[3]), .full(ful[3]),
        .error(err[3]), .data_out(dout[3]));

    // u0 status as {empty, almost_empty, half_full, almost_full, full, error}
    wire [5:0] fl0 = {emp[0], aemp[0], hf[0], af[0], ful[0], err[0]};

    // Drive one cycle of stimulus, then settle just past the edge.
    task automatic cyc(input bit r, input bit ps, input bit pp, input bit dg, input logic [7:0] d);
        rst = r; push_n = ~ps; pop_n = ~pp; diag_n = ~dg; din = d;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (3) cyc(1, 0, 0, 0, 8'h00);
        n_vec++; if (fl0 !== 6'b110000) begin n_bad++; $display("FAIL reset_flags: got %b want %b", fl0, 6'b110000); end
        n_vec++; if (dout[0] !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", dout[0]); end
        n_vec++; if (err !== 4'b0000) begin n_bad++; $display("FAIL reset_err: got %b want 0000", err); end
        n_vec++; if ({emp[3], aemp[3], hf[3], af[3], ful[3]} !== 5'b11000) begin
            n_bad++; $display("FAIL reset_flags_d5: got %b want 11000", {emp[3], aemp[3], hf[3], af[3], ful[3]});
        end
    endtask

    task automatic test_push_one;
        cyc(0, 1, 0, 0, 8'h01);
        n_vec++; if (fl0 !== 6'b011100) begin n_bad++; $display("FAIL push1_flags: got %b want %b", fl0, 6'b011100); end
        n_vec++; if (dout[0] !== 8'h01) begin n_bad++; $display("FAIL push1_dout: got %h want 01", dout[0]); end
    endtask

    task automatic test_fill_drain;
        cyc(0, 1, 0, 0, 8'h04);
        n_vec++; if (fl0 !== 6'b001110) begin n_bad++; $display("FAIL fill_flags: got %b want %b", fl0, 6'b001110); end
        n_vec++; if (dout[0] !== 8'h01) begin n_bad++; $display("FAIL fill_dout: got %h want 01", dout[0]); end
        cyc(0, 0, 1, 0, 8'h00);
        n_vec++; if (fl0 !== 6'b011100) begin n_bad++; $display("FAIL pop1_flags: got %b want %b", fl0, 6'b011100); end
        n_vec++; if (dout[0] !== 8'h04) begin n_bad++; $display("FAIL pop1_dout: got %h want 04", dout[0]); end
        cyc(0, 0, 1, 0, 8'h00);
        n_vec++; if (fl0 !== 6'b110000) begin n_bad++; $display("FAIL pop2_flags: got %b want %b", fl0, 6'b110000); end
    endtask

    task automatic test_overflow_wrap;
        cyc(0, 1, 0, 0, 8'h01);
        cyc(0, 1, 0, 0, 8'h04);
        cyc(0, 1, 0, 0, 8'hAA);
        n_vec++; if (fl0 !== 6'b001111) begin n_bad++; $display("FAIL ovf_flags: got %b want %b", fl0, 6'b001111); end
        n_vec++; if (err[2:1] !== 2'b11) begin n_bad++; $display("FAIL ovf_err12: got %b want 11", err[2:1]); end
        n_vec++; if (dout[0] !== 8'h01) begin n_bad++; $display("FAIL ovf_head: got %h want 01", dout[0]); end
        cyc(0, 0, 0, 0, 8'h00);
        n_vec++; if (err[2:0] !== 3'b011) begin n_bad++; $display("FAIL ovf_sticky: got %b want 011", err[2:0]); end
        cyc(0, 0, 1, 0, 8'h00);
        n_vec++; if (dout[0] !== 8'h04) begin n_bad++; $display("FAIL ovf_second: got %h want 04", dout[0]); end
        cyc(0, 0, 1, 0, 8'h00);
        n_vec++; if (fl0 !== 6'b110001) begin n_bad++; $display("FAIL ovf_drained: got %b want %b", fl0, 6'b110001); end
        cyc(1, 0, 0, 0, 8'h00);
        n_vec++; if (fl0 !== 6'b110000) begin n_bad++; $display("FAIL ovf_rst: got %b want %b", fl0, 6'b110000); end
        // five words through depth 2 with one in flight, so both pointers wrap twice
        cyc(0, 1, 0, 0, 8'h50);
        for (int i = 1; i < 5; i++) begin
            cyc(0, 1, 1, 0, 8'(8'h50 + i));
            n_vec++; if (dout[0] !== 8'(8'h50 + i) || fl0 !== 6'b011100) begin
                n_bad++; $display("FAIL wrap_%0d: got %h/%b want %h/011100", i, dout[0], fl0, 8'(8'h50 + i));
            end
        end
        cyc(0, 0, 1, 0, 8'h00);
        n_vec++; if (fl0 !== 6'b110000) begin n_bad++; $display("FAIL wrap_end: got %b want %b", fl0, 6'b110000); end
    endtask

    task automatic test_underflow;
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        n_vec++; if (err[2:1] !== 2'b11) begin n_bad++; $display("FAIL unf_set: got %b want 11", err[2:1]); end
        cyc(0, 0, 0, 0, 8'h00);
        n_vec++; if (err[2:1] !== 2'b01) begin n_bad++; $display("FAIL unf_pulse: got %b want 01", err[2:1]); end
        cyc(0, 0, 0, 0, 8'h00);
        n_vec++; if (err[2:1] !== 2'b01) begin n_bad++; $display("FAIL unf_hold: got %b want 01", err[2:1]); end
        cyc(1, 0, 0, 0, 8'h00);
        n_vec++; if (err[1] !== 1'b0) begin n_bad++; $display("FAIL unf_rst: got %b want 0", err[1]); end
    endtask

    task automatic test_simul;
        cyc(0, 1, 0, 0, 8'h11);
        cyc(0, 1, 1, 0, 8'h22);
        n_vec++; if (fl0 !== 6'b011100 || dout[0] !== 8'h22) begin
            n_bad++; $display("FAIL simul_mid: got %b/%h want 011100/22", fl0, dout[0]);
        end
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'h33);
        n_vec++; if (fl0 !== 6'b011101 || dout[0] !== 8'h33) begin
            n_bad++; $display("FAIL simul_empty: got %b/%h want 011101/33", fl0, dout[0]);
        end
        n_vec++; if (err[2] !== 1'b1) begin n_bad++; $display("FAIL simul_pulse: got %b want 1", err[2]); end
    endtask

    task automatic test_diag;
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 1, 8'h00);
        n_vec++; if (err !== 4'b0001) begin n_bad++; $display("FAIL diag_set: got %b want 0001", err); end
        cyc(0, 0, 0, 0, 8'h00);
        n_vec++; if (err !== 4'b0001) begin n_bad++; $display("FAIL diag_hold: got %b want 0001", err); end
    endtask

    task automatic test_random;
        logic [7:0] q2[$], q5[$];
        bit e0, e1, e2, e3, r, ps, pp, dg, ov2, un2, ov5, un5;
        logic [7:0] d;
        logic [5:0] x0, x3;
        int pr;
        cyc(1, 0, 0, 0, 8'h00);
        {e0, e1, e2, e3} = '0;
        for (int i = 0; i < 600; i++) begin
            pr = ((i / 40) % 2 == 0) ? 70 : 30;
            r  = ($urandom_range(0, 59) == 0);
            ps = ($urandom_range(0, 99) < pr);
            pp = ($urandom_range(0, 99) < 100 - pr);
            dg = ($urandom_range(0, 19) == 0);
            d  = 8'($urandom);
            if (r) begin
                q2.delete(); q5.delete(); {e0, e1, e2, e3} = '0;
            end else begin
                ov2 = ps && q2.size() == 2; un2 = pp && q2.size() == 0;
                ov5 = ps && q5.size() == 5; un5 = pp && q5.size() == 0;
                if (pp && q2.size() > 0) void'(q2.pop_front());
                if (ps && !ov2) q2.push_back(d);
                if (pp && q5.size() > 0) void'(q5.pop_front());
                if (ps && !ov5) q5.push_back(d);
                e0 = e0 | ov2 | un2 | dg;
                e1 = e1 | ov2 | un2;
                e2 = ov2 | un2;
                e3 = ov5 | un5;
            end
            cyc(r, ps, pp, dg, d);
            x0 = {q2.size() == 0, q2.size() <= 1, q2.size() >= 1, q2.size() >= 1, q2.size() == 2, e0};
            x3 = {q5.size() == 0, q5.size() <= 2, q5.size() >= 3, q5.size() >= 4, q5.size() == 5, e3};
            n_vec++; if (fl0 !== x0) begin n_bad++; $display("FAIL rnd%0d_d2_flags: got %b want %b", i, fl0, x0); end
            n_vec++; if ({emp[3], aemp[3], hf[3], af[3], ful[3], err[3]} !== x3) begin
                n_bad++; $display("FAIL rnd%0d_d5_flags: got %b want %b", i, {emp[3], aemp[3], hf[3], af[3], ful[3], err[3]}, x3);
            end
            n_vec++; if (err[2:1] !== {e2, e1}) begin n_bad++; $display("FAIL rnd%0d_err12: got %b want %b", i, err[2:1], {e2, e1}); end
            if (q2.size() > 0) begin
                n_vec++; if (dout[0] !== q2[0]) begin n_bad++; $display("FAIL rnd%0d_d2_dout: got %h want %h", i, dout[0], q2[0]); end
            end
            if (q5.size() > 0) begin
                n_vec++; if (dout[3] !== q5[0]) begin n_bad++; $display("FAIL rnd%0d_d5_dout: got %h want %h", i, dout[3], q5[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_push_one();
        test_fill_drain();
        test_overflow_wrap();
        test_underflow();
        test_simul();
        test_diag();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_s1_sf.md
# fifo_s1_sf

Single-clock synchronous FIFO with registered status flags and first-word-fall-through output. It buffers `width`-bit words, such as AXI read-burst lengths, between a producer and a consumer in the same clock domain. It reports empty, almost-empty, half-full, almost-full and full levels, plus an overflow/underflow error.

## Interface
Parameters:
- `width`, 8: data word width, 1..256.
- `depth`, 4: number of words, 2..256; non-power-of-2 values are legal.
- `ae_level`, 1: almost-empty threshold, 1..depth-1.
- `af_level`, 1: almost-full threshold, 1..depth-1.
- `err_mode`, 0: 0 = sticky error including diag; 1 = sticky error, overflow/underflow only; 2 = non-sticky error.
- `rst_mode`, 0: 0 = reset clears the memory array; 1 = reset clears pointers and flags only.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `push_req_n`, in, 1: push request, active low.
- `pop_req_n`, in, 1: pop request, active low.
- `diag_n`, in, 1: diagnostic, active low; acts only when err_mode=0.
- `data_in`, in, width: write data.
- `empty`, out, 1: count==0.
- `almost_empty`, out, 1: count<=ae_level.
- `half_full`, out, 1: count>=(depth+1)/2.
- `almost_full`, out, 1: count>=depth-af_level.
- `full`, out, 1: count==depth.
- `error`, out, 1: overflow/underflow/diag error.
- `data_out`, out, width: word at the head of the FIFO.

## Operation
- State:
  - `wr_ptr` and `rd_ptr`, each $clog2(depth) bits. Each wraps from depth-1 to 0 by explicit compare, not by power-of-2 rollover.
  - `count`, $clog2(depth+1) bits.
  - Memory `mem[depth]`.
- Push accepted (push_req_n=0, not full): `mem[wr_ptr]<=data_in`, wr_ptr advances, count+1.
- Pop accepted (pop_req_n=0, not empty): rd_ptr advances, count-1.
- Simultaneous push and pop:
  - 0<count<depth: both are performed and count is unchanged.
  - Empty: push only, and underflow is flagged.
  - Full: pop only; the push is dropped and overflow is flagged.
- Push while full: data is discarded, state unchanged, overflow flagged.
- Pop while empty: state unchanged, underflow flagged.
- Error (`err_event` = overflow or underflow):
  - err_mode 0: error sets on err_event, or on diag_n=0, and holds until rst.
  - err_mode 1: error sets on err_event only and holds until rst; diag_n is ignored.
  - err_mode 2: error equals err_event registered, a one-cycle pulse.
- `data_out = mem[rd_ptr]`, read combinationally; it is valid whenever `empty=0`.
- Reset:
  - Pointers and count are cleared; empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0.
  - rst_mode 0: memory is cleared, so data_out=0.
  - rst_mode 1: memory is untouched, so data_out equals the stale mem[0].
- Reset during traffic: rst wins over push and pop in the same cycle.

## Timing
- Flags and error are registered and are derived from next-state count. They reflect a push or pop on the clock edge that accepts it (visible in the next cycle).
- Latency from push to data_out is one edge when the FIFO was empty (first word falls through).
- After a pop edge, data_out shows the next word in the same cycle rd_ptr updates. There is no read pipeline.
- No ready/valid handshake: the requester checks full/empty before asserting a request.

## Configuration
- `FIFO_S1_SF_ASSERT_EN` defined:
  - Elaboration checks of every parameter range.
  - Concurrent assertions: count<=depth; full and empty never both set; a `$error` on each overflow/underflow.
- Undefined: no assertion code is compiled. RTL behaviour is identical in both cases.

## Structure
- Package `fifo_s1_sf_pkg`:
  - Constants `ERR_MODE_STICKY_DIAG=0`, `ERR_MODE_STICKY=1`, `ERR_MODE_PULSE=2`, `RST_MODE_MEM=0`, `RST_MODE_PTR=1`.
  - Function `ptr_inc(ptr, depth)` implementing the wrap.
- Sub-module `fifo_s1_sf_ctl`: pointers, count, flags, error. The top holds the memory array and the data_out mux.

## Test plan
Configuration for all scenarios: width=8, depth=2, ae_level=1, af_level=1, err_mode=0, rst_mode=0.

1. Reset for 3 cycles: empty=1, almost_empty=1, half_full=0, almost_full=0, full=0, error=0, data_out=0x00.
2. Push 0x01 for one cycle: next cycle empty=0, almost_empty=1, half_full=1, almost_full=1, full=0, data_out=0x01.
3. Push 0x04: full=1, almost_empty=0, data_out=0x01. Pop: data_out=0x04, full=0. Pop again: empty=1, error=0.
4. Overflow and wrap:
   - With the FIFO full, push 0xAA: error=1 (sticky), FIFO contents remain 0x01 then 0x04.
   - After rst: error=0, then push/pop 5 words through depth 2, checking wrap-around order.
5. Underflow per err_mode:
   - err_mode=2, pop while empty: error high for exactly 1 cycle.
   - err_mode=1, same stimulus: error stays high until rst.
6. Simultaneous push/pop:
   - count=1 holding 0x11, push 0x22 with pop: count stays 1, data_out=0x22.
   - While empty: push is accepted and error=1 (underflow).
